apb_manager_multi: RTL

//  Parametrised APB4 manager: takes single requests from an upstream bridge over a

---
 rtl/apb_manager_multi.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/apb_manager_multi.sv
// APB4 manager: accepts one upstream request at a time, runs a SETUP/ACCESS transfer to the
// subordinate decoded from the address, and returns a single response with a wait-state timeout.
module apb_manager_multi #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SUBS   = 8,
  parameter int SUB_SHIFT  = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  input  logic [DATA_WIDTH/8-1:0]        req_strb,
  input  logic [2:0]                     req_prot,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic [NUM_SUBS-1:0]            psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [ADDR_WIDTH-1:0]          paddr,
  output logic [DATA_WIDTH-1:0]          pwdata,
  output logic [DATA_WIDTH/8-1:0]        pstrb,
  output logic [2:0]                     pprot,
  input  logic [NUM_SUBS-1:0]            pready,
  input  logic [NUM_SUBS-1:0]            pslverr,
  input  logic [NUM_SUBS*DATA_WIDTH-1:0] prdata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SEL_W  = (NUM_SUBS > 1) ? $clog2(NUM_SUBS) : 1;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN  = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_e;

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic                    dec_err_q, dec_err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [NUM_SUBS-1:0]     psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;

  logic [SEL_W-1:0]        req_idx;
  logic                    req_dec_err;
  logic [NUM_SUBS-1:0]     req_onehot;
  logic                    sub_ready;
  logic                    sub_err;
  logic [DATA_WIDTH-1:0]   sub_rdata;

  assign req_idx     = req_addr[SUB_SHIFT +: SEL_W];
  assign req_dec_err = ({1'b0, req_idx} >= (SEL_W + 1)'(NUM_SUBS));

  // Request decode and per-subordinate response mux; only the latched target is ever looked at.
  always_comb begin
    req_onehot = '0;
    sub_ready  = 1'b0;
    sub_err    = 1'b0;
    sub_rdata  = '0;
    for (int i = 0; i < NUM_SUBS; i++) begin
      req_onehot[i] = (req_idx == SEL_W'(i));
      if (idx_q == SEL_W'(i)) begin
        sub_ready = pready[i];
        sub_err   = pslverr[i];
        sub_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // NOTE: every _d starts as its _q, so no path through the case leaves a signal unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dec_err_d   = dec_err_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          idx_d       = req_idx;
          dec_err_d   = req_dec_err;
          pwrite_d    = req_write;
          paddr_d     = req_addr;
          pwdata_d    = req_wdata;
          pstrb_d     = req_write ? req_strb : '0;
          pprot_d     = req_prot;
          psel_d      = req_dec_err ? '0 : req_onehot;
          state_d     = ST_SETUP;
        end
      end

      // A decode error spends this slot with psel low, then reports without touching the bus.
      ST_SETUP: begin
        if (dec_err_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_RESP;
        end else begin
          penable_d = 1'b1;
          state_d   = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (sub_ready) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = sub_err;
          rsp_rdata_d = (!pwrite_q && !sub_err) ? sub_rdata : '0;
          state_d     = ST_RESP;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      dec_err_q   <= 1'b0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dec_err_q   <= dec_err_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign pprot     = pprot_q;

endmodule
